// File: rtl/p3_fifo_pkg.sv
// Shared types and constants for the P3 capture FIFO write-side logic.
// The FIFO word is a 16-bit payload plus an end-of-frame flag in bit 16.
package p3_fifo_pkg;

    localparam int WORD_W  = 17;
    localparam int EOF_BIT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    // An abort word always closes the frame, so its EOF flag is forced high.
    function automatic logic [WORD_W-1:0] abort_word(input logic [15:0] payload);
        return {1'b1, payload};
    endfunction

endpackage

// File: rtl/p3_fifo_wr_arbiter_if.sv
// Requester and FIFO write-port bundle for the P3 write arbiter.
// slave = arbiter side, master = front-ends plus FIFO flags.
interface p3_fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 2
);

    logic [NUM_REQ-1:0]                        req_valid;
    logic [NUM_REQ*p3_fifo_pkg::WORD_W-1:0]    req_data;
    logic [NUM_REQ-1:0]                        req_ready;
    logic [NUM_REQ-1:0]                        grant;
    logic [p3_fifo_pkg::WORD_W-1:0]            fifo_data;
    logic                                      fifo_we;
    logic                                      fifo_afull;
    logic                                      fifo_full;

    modport slave (
        input  req_valid, req_data, fifo_afull, fifo_full,
        output req_ready, grant, fifo_data, fifo_we
    );

    modport master (
        output req_valid, req_data, fifo_afull, fifo_full,
        input  req_ready, grant, fifo_data, fifo_we
    );

endinterface

// File: rtl/p3_rr_pick.sv
// Round-robin picker: first asserted request strictly after rr_ptr, wrapping.
// Purely combinational so read-side schedulers can reuse it.
module p3_rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     pick,
    output logic             any_req
);

    logic found;
    int   idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/p3_fifo_wr_arbiter.sv
// Frame-granular round-robin arbiter onto the P3 capture FIFO write port,
// with AFULL throttling and stalled-frame abort.
//   state | meaning
//   IDLE  | no grant; pick next requester round-robin
//   BUSY  | grant held until an EOF word transfers or the stall timer expires
//   ABORT | waiting for AFULL low to insert the abort word
module p3_fifo_wr_arbiter
    import p3_fifo_pkg::*;
#(
    parameter int          NUM_REQ       = 2,
    parameter int          STALL_TIMEOUT = 255,
    parameter logic [15:0] ABORT_PAYLOAD = 16'hDEAD
) (
    input  logic                clock,
    input  logic                reset,
    p3_fifo_wr_arbiter_if.slave bus,
    output logic                overflow,
    output logic                timeout,
    output logic [15:0]         frame_count
);

    localparam int          PTR_W      = $clog2(NUM_REQ);
    localparam logic [15:0] STALL_LOAD = 16'(STALL_TIMEOUT);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] grant, pick;
    logic [PTR_W-1:0]   rr_ptr, grant_idx, pick_idx;
    logic               any_req;
    logic [15:0]        stall_cnt;
    logic [WORD_W-1:0]  g_word, fifo_data;
    logic               g_valid, fifo_we;
    logic               do_grant, do_xfer, do_eof, do_expire, do_abort, stall_tick;

    p3_rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr),
        .pick    (pick),
        .any_req (any_req)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) pick_idx = PTR_W'(i);
        end
    end

    always_comb begin
        g_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) g_word = g_word | bus.req_data[WORD_W*i +: WORD_W];
        end
    end

    assign g_valid       = |(bus.req_valid & grant);
    assign bus.grant     = grant;
    assign bus.req_ready = (state == BUSY && !bus.fifo_afull) ? grant : '0;
    assign bus.fifo_data = fifo_data;
    assign bus.fifo_we   = fifo_we;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Stall cycles only count while the FIFO can accept; AFULL freezes the timer.
    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_xfer    = 1'b0;
        do_eof     = 1'b0;
        do_expire  = 1'b0;
        do_abort   = 1'b0;
        stall_tick = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    do_grant  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!bus.fifo_afull) begin
                    if (g_valid) begin
                        do_xfer = 1'b1;
                        if (g_word[EOF_BIT]) begin
                            do_eof    = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        stall_tick = 1'b1;
                        if (stall_cnt == 16'd1) begin
                            do_expire = 1'b1;
                            state_nxt = ABORT;
                        end
                    end
                end
            end
            ABORT: begin
                if (!bus.fifo_afull) begin
                    do_abort  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant       <= '0;
            grant_idx   <= '0;
            rr_ptr      <= PTR_W'(NUM_REQ - 1);
            stall_cnt   <= STALL_LOAD;
            fifo_data   <= '0;
            fifo_we     <= 1'b0;
            overflow    <= 1'b0;
            timeout     <= 1'b0;
            frame_count <= '0;
        end else begin
            fifo_we  <= 1'b0;
            timeout  <= 1'b0;
            overflow <= overflow | (fifo_we & bus.fifo_full);

            if (do_grant) begin
                grant     <= pick;
                grant_idx <= pick_idx;
            end

            if (do_grant || do_xfer || do_abort) stall_cnt <= STALL_LOAD;
            else if (stall_tick)                 stall_cnt <= stall_cnt - 16'd1;

            if (do_xfer) begin
                fifo_we   <= 1'b1;
                fifo_data <= g_word;
            end

            if (do_eof) begin
                grant       <= '0;
                rr_ptr      <= grant_idx;
                frame_count <= frame_count + 16'd1;
            end

            if (do_expire) grant <= '0;

            if (do_abort) begin
                fifo_we   <= 1'b1;
                fifo_data <= abort_word(ABORT_PAYLOAD);
                timeout   <= 1'b1;
                rr_ptr    <= grant_idx;
            end
        end
    end

endmodule
